// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] MemoryAddress,
  output logic        memRD,
  output logic        memWD,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} stateT;

  stateT       stateReg, stateNext;
  logic        loadReg, unsignedReg;
  logic [1:0]  sizeReg;
  logic [31:0] addrReg, wdataReg, rdWordReg;
  logic [3:0]  cntReg;
  logic [31:0] respRdataReg;
  logic        respErrReg;

  logic        accept, reqErr, rdDone;
  logic [3:0]  byteEn;
  logic [31:0] laneData, mergedWord, loadShifted, loadResult;

  assign accept = (stateReg == IDLE) && req_valid;
  assign reqErr = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign rdDone = (stateReg == RD) && (cntReg == 4'd0);

  // Store lane enables and store data replicated into every candidate lane
  always_comb begin
    byteEn   = 4'b1111;
    laneData = wdataReg;
    case (sizeReg)
      2'b00: begin
        byteEn   = 4'b0001 << addrReg[1:0];
        laneData = {4{wdataReg[7:0]}};
      end
      2'b01: begin
        byteEn   = addrReg[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wdataReg[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign mergedWord[8*gi +: 8] = byteEn[gi] ? laneData[8*gi +: 8] : rdWordReg[8*gi +: 8];
    end
  endgenerate

  assign loadShifted = DataOut >> {addrReg[1:0], 3'b000};

  always_comb begin
    case (sizeReg)
      2'b00:   loadResult = {{24{~unsignedReg & loadShifted[7]}}, loadShifted[7:0]};
      2'b01:   loadResult = {{16{~unsignedReg & loadShifted[15]}}, loadShifted[15:0]};
      default: loadResult = DataOut;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext     = stateReg;
    req_ready     = 1'b0;
    memRD         = 1'b0;
    memWD         = 1'b0;
    resp_valid    = 1'b0;
    MemoryAddress = 32'd0;
    DataIn        = 32'd0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reqErr)                              stateNext = RESP;
          else if (!req_load && req_size == 2'b10) stateNext = WR;
          else                                     stateNext = RD;
        end
      end
      RD: begin
        memRD         = 1'b1;
        MemoryAddress = {addrReg[31:2], 2'b00};
        if (cntReg == 4'd0) stateNext = loadReg ? RESP : WR;
      end
      WR: begin
        memWD         = 1'b1;
        MemoryAddress = {addrReg[31:2], 2'b00};
        DataIn        = mergedWord;
        stateNext     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Response fields change only on entry to RESP so they hold between responses
  always_ff @(posedge clk) begin
    if (!Reset) begin
      loadReg      <= 1'b0;
      unsignedReg  <= 1'b0;
      sizeReg      <= 2'b00;
      addrReg      <= 32'd0;
      wdataReg     <= 32'd0;
      rdWordReg    <= 32'd0;
      cntReg       <= 4'd0;
      respRdataReg <= 32'd0;
      respErrReg   <= 1'b0;
    end else begin
      if (accept) begin
        loadReg     <= req_load;
        unsignedReg <= req_unsigned;
        sizeReg     <= req_size;
        addrReg     <= req_addr;
        wdataReg    <= req_wdata;
        cntReg      <= 4'(RD_LATENCY - 1);
      end else if (stateReg == RD && cntReg != 4'd0) begin
        cntReg <= cntReg - 4'd1;
      end
      if (rdDone) rdWordReg <= DataOut;
      if (accept && reqErr) begin
        respErrReg   <= 1'b1;
        respRdataReg <= 32'd0;
      end else if (rdDone && loadReg) begin
        respErrReg   <= 1'b0;
        respRdataReg <= loadResult;
      end else if (stateReg == WR) begin
        respErrReg   <= 1'b0;
        respRdataReg <= 32'd0;
      end
    end
  end

  assign resp_rdata = respRdataReg;
  assign resp_err   = respErrReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Drives two units (read latency 1 and 3) with identical requests and checks every
// cycle against a word-array reference model of loads, stores and error rules.
module tb_mem_access_unit;

  logic        clk;
  logic        Reset;
  logic        req_valid, req_load, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        readyV[2], respValidV[2], respErrV[2], memRDv[2], memWDv[2];
  logic [31:0] respRdataV[2], memAddrV[2], dataInV[2], dataOutV[2];

  logic [31:0] simMem[2][256];
  logic [31:0] initWord[256];
  logic [31:0] refMem[256];
  logic        memInit;

  int          latV[2] = '{1, 3};
  logic        heldErr[2];
  logic [31:0] heldRdata[2];
  int          total = 0;
  int          bad = 0;

  logic        nLd, nUs;
  logic [1:0]  nSz;
  logic [31:0] nAddr, nWd;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gDut
      mem_access_unit #(.RD_LATENCY(g == 0 ? 1 : 3)) dut (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(readyV[g]),
        .req_load(req_load), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(respValidV[g]), .resp_rdata(respRdataV[g]), .resp_err(respErrV[g]),
        .MemoryAddress(memAddrV[g]), .memRD(memRDv[g]), .memWD(memWDv[g]),
        .DataIn(dataInV[g]), .DataOut(dataOutV[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (memInit) begin
        for (int w = 0; w < 256; w++) simMem[i][w] <= initWord[w];
      end else if (memWDv[i]) begin
        simMem[i][memAddrV[i][9:2]] <= dataInV[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      dataOutV[i] = memRDv[i] ? simMem[i][memAddrV[i][9:2]] : 32'h0BADF00D;
  end

  function automatic logic [100:0] obsVec(int i);
    return {readyV[i], memRDv[i], memWDv[i], respValidV[i], respErrV[i],
            memAddrV[i], dataInV[i], respRdataV[i]};
  endfunction

  task automatic checkOne(input int i, input string tag, input int k, input logic [100:0] exp);
    logic [100:0] got;
    got = obsVec(i);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cycle%0d got=%h exp=%h (rdy,rd,wd,rv,err,addr,din,rdata)",
             tag, i, k, got, exp);
    end
  endtask

  task automatic memCheck(input string tag, input logic [7:0] wa);
    for (int i = 0; i < 2; i++) begin
      total++;
      assert (simMem[i][wa] === refMem[wa]) else begin
        bad++;
        $error("FAIL %s mem dut%0d word%0d got=%h exp=%h", tag, i, wa, simMem[i][wa], refMem[wa]);
      end
    end
  endtask

  task automatic checkIdleZero(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < 2; i++) checkOne(i, tag, k, {1'b1, 100'd0});
      @(posedge clk); #1;
    end
  endtask

  // Entry: #1 after a rising edge with both units idle.
  task automatic runTxn(input string tag, input logic ld, input logic [1:0] sz, input logic us,
                        input logic [31:0] addr, input logic [31:0] wd, input bit keepValid);
    logic [31:0] old, mask, merged, expRdata, waddr;
    logic        isErr, rdOn, wrOn;
    int          sh, maxEnd;
    int          rdLast[2], wrK[2], endK[2];
    old   = refMem[addr[9:2]];
    sh    = 8 * int'(addr[1:0]);
    waddr = {addr[31:2], 2'b00};
    isErr = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    merged = (old & ~(mask << sh)) | ((wd & mask) << sh);
    expRdata = 32'd0;
    if (!isErr && ld) begin
      expRdata = (old >> sh) & mask;
      if (!us && sz == 2'd0 && expRdata[7])  expRdata = expRdata | 32'hFFFF_FF00;
      if (!us && sz == 2'd1 && expRdata[15]) expRdata = expRdata | 32'hFFFF_0000;
    end
    maxEnd = 0;
    for (int i = 0; i < 2; i++) begin
      if (isErr)          begin rdLast[i] = 0;       wrK[i] = 0;           endK[i] = 1; end
      else if (ld)        begin rdLast[i] = latV[i]; wrK[i] = 0;           endK[i] = latV[i] + 1; end
      else if (sz == 2'd2) begin rdLast[i] = 0;      wrK[i] = 1;           endK[i] = 2; end
      else                begin rdLast[i] = latV[i]; wrK[i] = latV[i] + 1; endK[i] = latV[i] + 2; end
      if (endK[i] > maxEnd) maxEnd = endK[i];
    end
    req_valid = 1'b1; req_load = ld; req_size = sz; req_unsigned = us;
    req_addr = addr;  req_wdata = wd;
    @(posedge clk); #1;
    if (keepValid) begin
      req_load = nLd; req_size = nSz; req_unsigned = nUs; req_addr = nAddr; req_wdata = nWd;
    end else begin
      req_valid = 1'b0; req_load = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end
    for (int k = 1; k <= maxEnd + 1; k++) begin
      for (int i = 0; i < 2; i++) begin
        rdOn = (k <= rdLast[i]);
        wrOn = (k == wrK[i]);
        checkOne(i, tag, k, {(k > endK[i]), rdOn, wrOn, (k == endK[i]),
                             (k >= endK[i]) ? isErr : heldErr[i],
                             (rdOn || wrOn) ? waddr : 32'd0,
                             wrOn ? merged : 32'd0,
                             (k >= endK[i]) ? expRdata : heldRdata[i]});
      end
      if (k <= maxEnd) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 2; i++) begin heldErr[i] = isErr; heldRdata[i] = expRdata; end
    if (!ld && !isErr) refMem[addr[9:2]] = merged;
    memCheck(tag, addr[9:2]);
    $display("txn %s ld=%0d sz=%0d us=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
             tag, ld, sz, us, addr, wd, expRdata, isErr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rLd, rUs;
    logic [1:0]  rSz;
    logic [31:0] rAddr;
    for (int w = 0; w < 256; w++) initWord[w] = $urandom;
    initWord[8'h40] = 32'h8899_AABB;
    for (int w = 0; w < 256; w++) refMem[w] = initWord[w];
    for (int i = 0; i < 2; i++) begin heldErr[i] = 1'b0; heldRdata[i] = 32'd0; end
    nLd = 1'b0; nUs = 1'b0; nSz = 2'd0; nAddr = 32'd0; nWd = 32'd0;

    Reset = 1'b0; memInit = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    memInit = 1'b0;
    for (int i = 0; i < 2; i++) checkOne(i, "reset_state", 0, {1'b1, 100'd0});
    Reset = 1'b1;
    @(posedge clk); #1;

    runTxn("lb_0x103",  1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 1'b0);
    runTxn("lhu_0x102", 1'b1, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 1'b0);
    runTxn("lw_0x100",  1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
    runTxn("sb_0x101",  1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h1234_5677, 1'b0);
    runTxn("lw_0x102_misaligned", 1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 1'b0);
    runTxn("lh_0x101_misaligned", 1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'd0, 1'b0);
    runTxn("size11_store", 1'b0, 2'd3, 1'b0, 32'h0000_0104, 32'hFFFF_FFFF, 1'b0);

    // reset coincident with an accept edge: the store is dropped
    req_valid = 1'b1; req_load = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0200; req_wdata = 32'hCAFE_F00D; Reset = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b1; req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin heldErr[i] = 1'b0; heldRdata[i] = 32'd0; end
    checkIdleZero("rst_at_accept", 5);
    memCheck("rst_at_accept", 8'h80);
    $display("txn rst_at_accept sw addr=00000200 dropped");

    // reset while a read-modify-write is in its read phase
    runTxn("lw_before_abort", 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
    req_valid = 1'b1; req_load = 1'b0; req_size = 2'd0; req_addr = 32'h0000_0104;
    req_wdata = 32'h0000_00A5;
    @(posedge clk); #1;
    req_valid = 1'b0; Reset = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin heldErr[i] = 1'b0; heldRdata[i] = 32'd0; end
    checkIdleZero("rst_mid_rmw", 6);
    memCheck("rst_mid_rmw", 8'h41);
    $display("txn rst_mid_rmw sb addr=00000104 aborted");

    // back-to-back: valid stays high, the load waits for the idle cycle after RESP
    nLd = 1'b1; nSz = 2'd2; nUs = 1'b0; nAddr = 32'h0000_0300; nWd = 32'd0;
    runTxn("b2b_sw", 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h5A5A_1234, 1'b1);
    runTxn("b2b_lw", 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rLd = 1'($urandom); rSz = 2'($urandom); rUs = 1'($urandom);
      rAddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rSz == 2'd1) rAddr[0] = 1'b0;
        if (rSz == 2'd2) rAddr[1:0] = 2'b00;
      end
      runTxn($sformatf("rand%0d", n), rLd, rSz, rUs, rAddr, $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: RD_LATENCY, 1, cycles memRD is held before DataOut is sampled (legal range 1..15).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: Reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 Port: req_valid  in  1  pipeline MEM-stage request present.
REQ-005 Port: req_ready  out  1  unit can accept a request this cycle.
REQ-006 Port: req_load  in  1  1=load, 0=store.
REQ-007 Port: req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 Port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
REQ-009 Port: req_addr  in  32  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-012 Port: resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-013 Port: resp_err  out  1  qualified by resp_valid; misaligned or illegal-size request.
REQ-014 Port: MemoryAddress  out  32  word address to data memory, bits [1:0] always 0.
REQ-015 Port: memRD  out  1  memory read strobe.
REQ-016 Port: memWD  out  1  memory write strobe.
REQ-017 Port: DataIn  out  32  full-word write data to memory.
REQ-018 Port: DataOut  in  32  full-word read data from memory.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields registered then, later changes ignored.
REQ-021 Error check at acceptance: req_size=11, half with addr[0]=1, or word with addr[1:0]!=00 SHALL go IDLE->RESP with resp_err=1 and no memRD/memWD.
REQ-022 Load (accepted cycle N): memRD=1 in cycles N+1..N+RD_LATENCY, DataOut sampled at the end of cycle N+RD_LATENCY, resp_valid=1 in N+RD_LATENCY+1.
REQ-023 Word store: memWD=1 in N+1 with DataIn=req_wdata; resp_valid=1 in N+2.
REQ-024 Byte/half store SHALL read-modify-write: RD as REQ-022, then memWD=1 in N+RD_LATENCY+1 with the sampled word merged with the new lane(s), resp_valid=1 in N+RD_LATENCY+2.
REQ-025 Lanes little-endian: byte at bits [8*addr[1:0]+7 : 8*addr[1:0]], half at bits [16*addr[1]+15 : 16*addr[1]]; unaffected bits preserved exactly.
REQ-026 Load result: selected lane shifted to bit 0, upper bits filled with 0 (unsigned) or lane MSB (signed); word loads unmodified.
REQ-027 MemoryAddress SHALL equal {req_addr[31:2],2'b00} from N+1 through the final RD/WR cycle, and 0 in IDLE and RESP.
REQ-028 memRD and memWD SHALL never both be 1; DataIn SHALL be 0 except in WR.
REQ-029 RESP SHALL last exactly one cycle then return to IDLE; no new request accepted during RESP.
REQ-030 resp_rdata and resp_err SHALL hold their last values until the next RESP; they are valid only while resp_valid=1.
REQ-031 RD SHALL use an internal counter loaded with RD_LATENCY-1 and decremented each cycle; exit on 0.

Reset
REQ-032 On a rising edge with Reset=0: state IDLE; req_ready=1 after release; resp_valid, resp_err, resp_rdata, MemoryAddress, memRD, memWD, DataIn all 0.
REQ-033 Reset asserted mid-transaction SHALL abort it: no memWD and no resp_valid for the aborted request after that edge.
REQ-034 Reset has priority over a simultaneous req_valid; that request is not accepted.

Verification
REQ-035 Word-in-memory 0x8899AABB at 0x100, LB addr 0x103 signed, RD_LATENCY=1 -> memRD in N+1, MemoryAddress=0x100, resp_valid in N+2, resp_rdata=0xFFFFFF88.
REQ-036 Same word, LHU addr 0x102 -> resp_rdata=0x00008899; LW addr 0x100 -> 0x8899AABB.
REQ-037 SB addr 0x101 wdata 0x12345677, RD_LATENCY=3 -> memRD N+1..N+3, memWD N+4 with DataIn=0x8899_77BB, resp_valid N+5, resp_err=0.
REQ-038 LW addr 0x102 -> resp_valid in N+1, resp_err=1, resp_rdata=0, memRD and memWD stay 0 throughout.
REQ-039 SW accepted, Reset=0 at edge ending cycle N -> memWD never 1, resp_valid never 1, all outputs 0, req_ready=1 after release.
REQ-040 Back-to-back req_valid held high for SW then LW -> second accepted only in the IDLE cycle after RESP; strobes never overlap.
